pkt_merge_arbiter: RTL and testbench

- Two-input, one-output packet merge arbiter placed upstream of the branch stage.
- Shares the single branch-stage packet input between two producer pipelines (A and B), e.g. two firing/matching lanes.
- Round-robin fairness; optional grant lock keeps multi-packet sequences from one source contiguous.
- Output is registered: one packet slot, sustained throughput of 1 packet per CP cycle.

---
 rtl/pkt_merge_arbiter.sv | 88 ++++++++
 tb/tb_pkt_merge_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/pkt_merge_arbiter.sv
// Two-input round-robin packet merge arbiter with optional grant lock and a
// single registered output slot (1 packet per cycle sustained).
module pkt_merge_arbiter #(
    parameter int PW       = 38,
    parameter int LOCK_BIT = 37
) (
    input  logic          CP,
    input  logic          MR,
    input  logic [PW-1:0] PACKET_IN_a,
    input  logic          Send_in_a,
    output logic          Ack_out_a,
    input  logic [PW-1:0] PACKET_IN_b,
    input  logic          Send_in_b,
    output logic          Ack_out_b,
    output logic [PW-1:0] PACKET_OUT,
    output logic          Send_out,
    input  logic          Ack_in,
    output logic          Lock_active
);

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_A    = 2'd1,
        LOCK_B    = 2'd2
    } lock_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_t;

    lock_t lock;
    src_t  last_grant;
    logic  grant_a;
    logic  grant_b;
    logic  space;

    // Output slot can take a packet when empty or being drained this cycle.
    assign space = ~Send_out | Ack_in;

    // Grant selection: a held lock pins the grant; otherwise round-robin on ties.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (lock)
            LOCK_A: grant_a = 1'b1;
            LOCK_B: grant_b = 1'b1;
            default: begin
                if (Send_in_a && !Send_in_b) begin
                    grant_a = 1'b1;
                end else if (Send_in_b && !Send_in_a) begin
                    grant_b = 1'b1;
                end else if (Send_in_a && Send_in_b) begin
                    if (last_grant == SRC_B) grant_a = 1'b1;
                    else                     grant_b = 1'b1;
                end
            end
        endcase
    end

    assign Ack_out_a = ~MR & Send_in_a & grant_a & space;
    assign Ack_out_b = ~MR & Send_in_b & grant_b & space;

    // Output slot, lock and round-robin state.
    always_ff @(posedge CP) begin
        if (MR) begin
            PACKET_OUT <= '0;
            Send_out   <= 1'b0;
            lock       <= LOCK_NONE;
            last_grant <= SRC_B;
        end else if (Ack_out_a) begin
            PACKET_OUT <= PACKET_IN_a;
            Send_out   <= 1'b1;
            last_grant <= SRC_A;
            lock       <= PACKET_IN_a[LOCK_BIT] ? LOCK_A : LOCK_NONE;
        end else if (Ack_out_b) begin
            PACKET_OUT <= PACKET_IN_b;
            Send_out   <= 1'b1;
            last_grant <= SRC_B;
            lock       <= PACKET_IN_b[LOCK_BIT] ? LOCK_B : LOCK_NONE;
        end else if (Ack_in) begin
            Send_out   <= 1'b0;
        end
    end

    assign Lock_active = (lock != LOCK_NONE);

endmodule

// File: tb/tb_pkt_merge_arbiter.sv
// Directed bench for pkt_merge_arbiter: expected acks and lock state are given
// per step; accepted packets go through a scoreboard queue to the output.
module tb_pkt_merge_arbiter;

    localparam int PW = 38;
    localparam logic [PW-1:0] LK = 38'h20_0000_0000;

    logic          clk = 1'b0;
    logic          mr = 1'b1;
    logic [PW-1:0] pkt_a = '0;
    logic          send_a = 1'b0;
    logic          ack_a;
    logic [PW-1:0] pkt_b = '0;
    logic          send_b = 1'b0;
    logic          ack_b;
    logic [PW-1:0] pkt_out;
    logic          send_out;
    logic          ack_in = 1'b0;
    logic          lock_active;

    int total = 0;
    int bad   = 0;
    logic [PW-1:0] sb_q[$];

    pkt_merge_arbiter #(.PW(PW), .LOCK_BIT(37)) dut (
        .CP(clk),
        .MR(mr),
        .PACKET_IN_a(pkt_a),
        .Send_in_a(send_a),
        .Ack_out_a(ack_a),
        .PACKET_IN_b(pkt_b),
        .Send_in_b(send_b),
        .Ack_out_b(ack_b),
        .PACKET_OUT(pkt_out),
        .Send_out(send_out),
        .Ack_in(ack_in),
        .Lock_active(lock_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock step: drive, check acks/output pop before the edge, then
    // check registered state after the edge.
    task automatic cyc(input logic m, input logic sa, input logic [PW-1:0] pa,
                       input logic sbv, input logic [PW-1:0] pb, input logic ai,
                       input logic ea, input logic eb, input logic el);
        logic [PW-1:0] exp_pkt;
        mr = m; send_a = sa; pkt_a = pa; send_b = sbv; pkt_b = pb; ack_in = ai;
        #2;
        check("ack_a", 64'(ack_a), 64'(ea));
        check("ack_b", 64'(ack_b), 64'(eb));
        if (m) begin
            sb_q.delete();
        end else begin
            if (sb_q.size() != 0 && ai) begin
                exp_pkt = sb_q.pop_front();
                check("pkt_out_drain", 64'(pkt_out), 64'(exp_pkt));
            end
            if (ea) sb_q.push_back(pa);
            if (eb) sb_q.push_back(pb);
        end
        @(posedge clk);
        #1;
        check("send_out", 64'(send_out), 64'(sb_q.size() != 0));
        check("lock_active", 64'(lock_active), 64'(el));
        if (m) check("pkt_out_reset", 64'(pkt_out), 64'd0);
        if (sb_q.size() != 0) check("pkt_out_held", 64'(pkt_out), 64'(sb_q[0]));
    endtask

    initial begin
        int na;
        int nb;
        logic ea;

        // Reset with both sources requesting: no acks, output cleared.
        cyc(1, 1, 38'h0_0000_00a1, 1, 38'h0_0000_00b1, 1, 0, 0, 0);
        cyc(1, 1, 38'h0_0000_00a1, 1, 38'h0_0000_00b1, 1, 0, 0, 0);
        // First tie after reset goes to A.
        cyc(0, 1, 38'h0_0000_00a1, 1, 38'h0_0000_00b1, 1, 1, 0, 0);
        cyc(0, 0, '0, 0, '0, 1, 0, 0, 0);

        // Single source back-to-back, then drain.
        cyc(0, 1, 38'h0_0010_0001, 0, '0, 1, 1, 0, 0);
        cyc(0, 1, 38'h0_0020_0002, 0, '0, 1, 1, 0, 0);
        cyc(0, 0, '0, 0, '0, 1, 0, 0, 0);
        cyc(0, 0, '0, 0, '0, 1, 0, 0, 0);

        // Lone B packet so the round-robin run starts with A.
        cyc(0, 0, '0, 1, 38'h0_0000_0bb0, 1, 0, 1, 0);
        cyc(0, 0, '0, 0, '0, 1, 0, 0, 0);

        // Round-robin: both continuous, 8 grants alternate A,B,...
        na = 0;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            ea = (i % 2 == 0);
            cyc(0, 1, 38'h100 + 38'(na), 1, 38'h200 + 38'(nb), 1, ea, !ea, 0);
            if (ea) na++;
            else    nb++;
        end
        check("rr_count_a", 64'(na), 64'd4);
        check("rr_count_b", 64'(nb), 64'd4);
        cyc(0, 0, '0, 0, '0, 1, 0, 0, 0);

        // Lock: A sends lock,lock,(gap 2),unlock while B sends throughout.
        cyc(0, 1, LK | 38'h0_0000_0a01, 1, 38'h0_0000_0b01, 1, 1, 0, 1);
        cyc(0, 1, LK | 38'h0_0000_0a02, 1, 38'h0_0000_0b01, 1, 1, 0, 1);
        cyc(0, 0, '0, 1, 38'h0_0000_0b01, 1, 0, 0, 1);
        cyc(0, 0, '0, 1, 38'h0_0000_0b01, 1, 0, 0, 1);
        cyc(0, 1, 38'h0_0000_0a03, 1, 38'h0_0000_0b01, 1, 1, 0, 0);
        cyc(0, 0, '0, 1, 38'h0_0000_0b01, 1, 0, 1, 0);
        cyc(0, 0, '0, 0, '0, 1, 0, 0, 0);

        // Backpressure: slot full, Ack_in low for 5 cycles.
        cyc(0, 1, 38'h0_0000_0c01, 1, 38'h0_0000_0d01, 1, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 38'h0_0000_0c02, 1, 38'h0_0000_0d01, 0, 0, 0, 0);
        cyc(0, 1, 38'h0_0000_0c02, 1, 38'h0_0000_0d01, 1, 0, 1, 0);
        cyc(0, 0, '0, 0, '0, 1, 0, 0, 0);

        // Reset while B holds the lock.
        cyc(0, 0, '0, 1, LK | 38'h0_0000_0e01, 0, 0, 1, 1);
        cyc(1, 1, 38'h0_0000_0f01, 1, 38'h0_0000_0e02, 1, 0, 0, 0);
        cyc(0, 1, 38'h0_0000_0f01, 1, 38'h0_0000_0e02, 1, 1, 0, 0);
        cyc(0, 0, '0, 0, '0, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
